atm: RTL and testbench

- Single-clock ATM transaction controller holding an internal 10-entry account database (account number, PIN, balance, lockout counter).
- A request on `operation` walks a fixed authentication/execute FSM. The FSM checks the account and PIN, then performs balance inquiry, deposit, withdrawal or PIN change.
- It reports the resulting balance and a success flag.
- It sits behind the user-interface/keypad logic; the database is register-based and is reloaded from constants at reset.

---
 rtl/atm_pkg.sv | 40 ++++
 rtl/atm_db.sv | 72 +++++++
 rtl/atm.sv | 172 +++++++++++++++++
 tb/tb_atm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared constants for the ATM controller: state codes, operation codes and
// the factory-default account database reloaded at every reset.
package atm_pkg;

    localparam int NUM_ACCOUNTS = 10;
    localparam int MAX_TRIES    = 3;
    localparam int BAL_W        = 14;
    localparam int ACC_W        = 11;
    localparam int OP_W         = 3;
    localparam int STATE_W      = 3;
    localparam int IDX_W        = $clog2(NUM_ACCOUNTS);
    localparam int TRY_W        = $clog2(MAX_TRIES + 1);
    localparam int BAL_MAX      = 16383;

    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_CHECK_ACC = 3'd1;
    localparam logic [STATE_W-1:0] S_CHECK_PIN = 3'd2;
    localparam logic [STATE_W-1:0] S_EXECUTE   = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE      = 3'd4;

    localparam logic [OP_W-1:0] OP_NONE       = 3'd0;
    localparam logic [OP_W-1:0] OP_BALANCE    = 3'd1;
    localparam logic [OP_W-1:0] OP_DEPOSIT    = 3'd2;
    localparam logic [OP_W-1:0] OP_WITHDRAW   = 3'd3;
    localparam logic [OP_W-1:0] OP_CHANGE_PIN = 3'd4;

    // Entry k: account 100*(k+1), PIN 1000+k, balance 1000*(k+1).
    function automatic logic [ACC_W-1:0] default_acc(input int k);
        return ACC_W'(100 * (k + 1));
    endfunction

    function automatic logic [BAL_W-1:0] default_pin(input int k);
        return BAL_W'(1000 + k);
    endfunction

    function automatic logic [BAL_W-1:0] default_bal(input int k);
        return BAL_W'(1000 * (k + 1));
    endfunction

endpackage

// File: rtl/atm_db.sv
// Register-based account database: parallel account-number lookup, one
// indexed read port and indexed write ports for balance, PIN and tries.
module atm_db
    import atm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] lookup_acc,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    input  logic [IDX_W-1:0] idx,
    output logic [BAL_W-1:0] rd_pin,
    output logic [BAL_W-1:0] rd_bal,
    output logic [TRY_W-1:0] rd_tries,
    input  logic             wr_bal_en,
    input  logic [BAL_W-1:0] wr_bal,
    input  logic             wr_pin_en,
    input  logic [BAL_W-1:0] wr_pin,
    input  logic             wr_tries_en,
    input  logic [TRY_W-1:0] wr_tries
);

    logic [ACC_W-1:0] acc_mem   [NUM_ACCOUNTS];
    logic [BAL_W-1:0] pin_mem   [NUM_ACCOUNTS];
    logic [BAL_W-1:0] bal_mem   [NUM_ACCOUNTS];
    logic [TRY_W-1:0] tries_mem [NUM_ACCOUNTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_ACCOUNTS; k++) begin
                acc_mem[k]   <= default_acc(k);
                pin_mem[k]   <= default_pin(k);
                bal_mem[k]   <= default_bal(k);
                tries_mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_ACCOUNTS; k++) begin
                if (idx == IDX_W'(k)) begin
                    if (wr_bal_en)   bal_mem[k]   <= wr_bal;
                    if (wr_pin_en)   pin_mem[k]   <= wr_pin;
                    if (wr_tries_en) tries_mem[k] <= wr_tries;
                end
            end
        end
    end

    // Lowest-numbered matching entry wins should two entries ever share a number.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_ACCOUNTS - 1; k >= 0; k--) begin
            if (acc_mem[k] == lookup_acc) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        rd_pin   = '0;
        rd_bal   = '0;
        rd_tries = '0;
        for (int k = 0; k < NUM_ACCOUNTS; k++) begin
            if (idx == IDX_W'(k)) begin
                rd_pin   = pin_mem[k];
                rd_bal   = bal_mem[k];
                rd_tries = tries_mem[k];
            end
        end
    end

endmodule

// File: rtl/atm.sv
// ATM transaction controller: authenticate account/PIN, then inquire,
// deposit, withdraw or change PIN. Define ATM_MSG_EN for a DONE message.
module atm
    import atm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    operation,
    input  logic [ACC_W-1:0]   acc_num,
    input  logic [BAL_W-1:0]   pin,
    input  logic [BAL_W-1:0]   newPin,
    input  logic [BAL_W-1:0]   amount,
    input  logic               language,
    output logic [BAL_W-1:0]   balance,
    output logic               success,
    output logic [STATE_W-1:0] state
);

    logic [OP_W-1:0]  op_q;
    logic [ACC_W-1:0] acc_q;
    logic [BAL_W-1:0] pin_q;
    logic [BAL_W-1:0] new_pin_q;
    logic [BAL_W-1:0] amount_q;
    logic [IDX_W-1:0] idx_q;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [BAL_W-1:0] rd_pin;
    logic [BAL_W-1:0] rd_bal;
    logic [TRY_W-1:0] rd_tries;

    logic             wr_bal_en;
    logic             wr_pin_en;
    logic             wr_tries_en;
    logic [TRY_W-1:0] wr_tries;

    logic             locked;
    logic             pin_ok;
    logic             exec_ok;
    logic [BAL_W-1:0] exec_bal;
    logic [BAL_W:0]   sum;

    // While searching, look at the matching entry; afterwards, at the latched one.
    assign rd_idx = (state == S_CHECK_ACC) ? hit_idx : idx_q;
    assign locked = (rd_tries == TRY_W'(MAX_TRIES));
    assign pin_ok = (rd_pin == pin_q);

    atm_db u_db (
        .clk         (clk),
        .rst         (rst),
        .lookup_acc  (acc_q),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .idx         (rd_idx),
        .rd_pin      (rd_pin),
        .rd_bal      (rd_bal),
        .rd_tries    (rd_tries),
        .wr_bal_en   (wr_bal_en),
        .wr_bal      (exec_bal),
        .wr_pin_en   (wr_pin_en),
        .wr_pin      (new_pin_q),
        .wr_tries_en (wr_tries_en),
        .wr_tries    (wr_tries)
    );

    always_comb begin
        sum      = {1'b0, rd_bal} + {1'b0, amount_q};
        exec_ok  = 1'b1;
        exec_bal = rd_bal;
        case (op_q)
            OP_BALANCE, OP_CHANGE_PIN: exec_ok = 1'b1;
            OP_DEPOSIT: begin
                if (sum > (BAL_W+1)'(BAL_MAX)) exec_ok = 1'b0;
                else                           exec_bal = sum[BAL_W-1:0];
            end
            OP_WITHDRAW: begin
                if (amount_q > rd_bal) exec_ok = 1'b0;
                else                   exec_bal = rd_bal - amount_q;
            end
            default: exec_ok = 1'b0;
        endcase
    end

    always_comb begin
        wr_bal_en   = (state == S_EXECUTE) && exec_ok &&
                      ((op_q == OP_DEPOSIT) || (op_q == OP_WITHDRAW));
        wr_pin_en   = (state == S_EXECUTE) && (op_q == OP_CHANGE_PIN);
        wr_tries_en = (state == S_CHECK_PIN);
        wr_tries    = '0;
        if (!pin_ok) wr_tries = locked ? rd_tries : rd_tries + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            balance   <= '0;
            success   <= 1'b0;
            op_q      <= OP_NONE;
            acc_q     <= '0;
            pin_q     <= '0;
            new_pin_q <= '0;
            amount_q  <= '0;
            idx_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (operation != OP_NONE) begin
                        op_q      <= operation;
                        acc_q     <= acc_num;
                        pin_q     <= pin;
                        new_pin_q <= newPin;
                        amount_q  <= amount;
                        success   <= 1'b0;
                        state     <= S_CHECK_ACC;
                    end
                end
                S_CHECK_ACC: begin
                    if (!hit || locked) begin
                        success <= 1'b0;
                        balance <= '0;
                        state   <= S_DONE;
                    end else begin
                        idx_q <= hit_idx;
                        state <= S_CHECK_PIN;
                    end
                end
                S_CHECK_PIN: begin
                    if (pin_ok) begin
                        state <= S_EXECUTE;
                    end else begin
                        success <= 1'b0;
                        balance <= '0;
                        state   <= S_DONE;
                    end
                end
                S_EXECUTE: begin
                    success <= exec_ok;
                    balance <= exec_bal;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    if (operation == OP_NONE) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ATM_MSG_EN
    logic                lang_q;
    logic [STATE_W-1:0]  prev_state;

    // Simulation-only receipt printed once per transaction on entry to DONE.
    always_ff @(posedge clk) begin
        prev_state <= state;
        if (state == S_IDLE && operation != OP_NONE) lang_q <= language;
        if (state == S_DONE && prev_state != S_DONE) begin
            if (lang_q)
                $display("atm: amaliya %0d natija %s rasid %0d", op_q,
                         success ? "najah" : "fashal", balance);
            else
                $display("atm: operation %0d result %s balance %0d", op_q,
                         success ? "ok" : "declined", balance);
        end
    end
`else
    logic unused_language;
    assign unused_language = language;
`endif

endmodule

// File: tb/tb_atm.sv
// Self-checking bench for atm: a behavioural account model predicts every
// DONE-state output; literal values from hand calculation pin the model.
module tb_atm;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  operation;
    logic [10:0] acc_num;
    logic [13:0] pin;
    logic [13:0] newPin;
    logic [13:0] amount;
    logic        language;
    logic [13:0] balance;
    logic        success;
    logic [2:0]  state;

    int tests_run = 0;
    int tests_failed = 0;

    int m_acc   [10];
    int m_pin   [10];
    int m_bal   [10];
    int m_tries [10];

    int exp_success;
    int exp_balance;
    bit exp_valid = 1'b0;

    atm dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .acc_num   (acc_num),
        .pin       (pin),
        .newPin    (newPin),
        .amount    (amount),
        .language  (language),
        .balance   (balance),
        .success   (success),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 10; k++) begin
            m_acc[k]   = 100 * (k + 1);
            m_pin[k]   = 1000 + k;
            m_bal[k]   = 1000 * (k + 1);
            m_tries[k] = 0;
        end
    endfunction

    // Account-level rules: lookup, lockout, PIN check, then the operation itself.
    function automatic void model_txn(input int op, input int acc, input int p,
                                      input int np, input int amt);
        int idx = -1;
        for (int k = 9; k >= 0; k--) if (m_acc[k] == acc) idx = k;
        exp_success = 0;
        exp_balance = 0;
        if (idx < 0 || m_tries[idx] >= 3) return;
        if (m_pin[idx] != p) begin
            m_tries[idx] = (m_tries[idx] + 1 > 3) ? 3 : m_tries[idx] + 1;
            return;
        end
        m_tries[idx] = 0;
        exp_balance = m_bal[idx];
        case (op)
            1: exp_success = 1;
            2: if (m_bal[idx] + amt <= 16383) begin
                   m_bal[idx] += amt;
                   exp_success = 1;
               end
            3: if (amt <= m_bal[idx]) begin
                   m_bal[idx] -= amt;
                   exp_success = 1;
               end
            4: begin
                   m_pin[idx] = np;
                   exp_success = 1;
               end
            default: exp_success = 0;
        endcase
        exp_balance = m_bal[idx];
    endfunction

    always @(negedge clk) begin
        if (exp_valid && state == 3'd4) begin
            checkOutput("cycle_success", success, exp_success);
            checkOutput("cycle_balance", balance, exp_balance);
        end
    end

    task automatic applyStimulus(input string name, input int op, input int acc,
                                 input int p, input int np, input int amt,
                                 input int lit_success, input int lit_balance);
        @(negedge clk);
        operation = 3'(op);
        acc_num   = 11'(acc);
        pin       = 14'(p);
        newPin    = 14'(np);
        amount    = 14'(amt);
        language  = 1'($urandom_range(0, 1));
        model_txn(op, acc, p, np, amt);
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_num = acc_num ^ 11'h2a5;
        pin     = pin ^ 14'h1555;
        newPin  = newPin ^ 14'h0f0f;
        amount  = amount ^ 14'h3333;
        repeat (3) @(posedge clk);
        #1;
        checkOutput({name, "_state"}, state, 4);
        checkOutput({name, "_success"}, success, lit_success);
        checkOutput({name, "_balance"}, balance, lit_balance);
        @(posedge clk);
        #1;
        checkOutput({name, "_hold"}, state, 4);
        @(negedge clk);
        operation = 3'd0;
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, "_idle"}, state, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        operation = 3'd0;
        exp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checkOutput("reset_state", state, 0);
        checkOutput("reset_success", success, 0);
        checkOutput("reset_balance", balance, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        operation = 3'd0;
        acc_num = '0;
        pin = '0;
        newPin = '0;
        amount = '0;
        language = 1'b0;
        doReset();

        applyStimulus("inq100",      1, 100,  1000, 0,    0,    1, 1000);
        applyStimulus("dep300",      2, 300,  1002, 0,    500,  1, 3500);
        applyStimulus("inq300",      1, 300,  1002, 0,    0,    1, 3500);
        applyStimulus("wd200_over",  3, 200,  1001, 0,    2500, 0, 2000);
        applyStimulus("wd200_all",   3, 200,  1001, 0,    2000, 1, 0);
        applyStimulus("chpin500",    4, 500,  1004, 4321, 0,    1, 5000);
        applyStimulus("oldpin500",   1, 500,  1004, 0,    0,    0, 0);
        applyStimulus("newpin500",   1, 500,  4321, 0,    0,    1, 5000);
        applyStimulus("bad700_1",    1, 700,  1,    0,    0,    0, 0);
        applyStimulus("bad700_2",    1, 700,  1,    0,    0,    0, 0);
        applyStimulus("bad700_3",    1, 700,  1,    0,    0,    0, 0);
        applyStimulus("locked700",   1, 700,  1006, 0,    0,    0, 0);

        doReset();
        applyStimulus("unlock700",   1, 700,  1006, 0,    0,    1, 7000);
        applyStimulus("noacc999",    1, 999,  1000, 0,    0,    0, 0);
        applyStimulus("ovf1000",     2, 1000, 1009, 0,    7000, 0, 10000);
        applyStimulus("dep_zero",    2, 100,  1000, 0,    0,    1, 1000);
        applyStimulus("wd_exact",    3, 100,  1000, 0,    1000, 1, 0);
        applyStimulus("invalid_op",  6, 200,  1001, 0,    0,    0, 2000);
        applyStimulus("dep_to_max",  2, 900,  1008, 0,    7383, 1, 16383);

        // Reset lands while the deposit sits in CHECK_PIN, before any write.
        @(negedge clk);
        operation = 3'd2;
        acc_num   = 11'd400;
        pin       = 14'd1003;
        amount    = 14'd100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        checkOutput("abort_state", state, 0);
        checkOutput("abort_success", success, 0);
        checkOutput("abort_balance", balance, 0);
        @(negedge clk);
        rst = 1'b0;
        operation = 3'd0;
        @(posedge clk);

        applyStimulus("after_abort", 1, 400,  1003, 0,    0,    1, 4000);
        applyStimulus("restored100", 1, 100,  1000, 0,    0,    1, 1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
